// File: rtl/ag_o_cfg.sv
// Runtime-configurable sys_out DPR address generator: walks (gamma, m) with stride r.
// Optional macro AG_O_CFG_CHECK_EN refuses zero-valued configuration at start.
module ag_o_cfg #(
  parameter int unsigned FEATURE_BITS = 4,
  parameter int unsigned ADDR_BITS    = 4
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [FEATURE_BITS-1:0] m_cfg,
  input  logic [FEATURE_BITS-1:0] gamma_cfg,
  input  logic [FEATURE_BITS-1:0] r_cfg,
  input  logic [ADDR_BITS-1:0]    base_cfg,
  input  logic                    mode_cont,
  input  logic                    stall,
  input  logic                    abort,
  output logic                    busy,
  output logic                    addr_vld,
  output logic [ADDR_BITS-1:0]    address,
  output logic [FEATURE_BITS-1:0] m_idx,
  output logic [FEATURE_BITS-1:0] g_idx,
  output logic                    last,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int unsigned ACC_BITS = 2 * FEATURE_BITS;
  localparam int unsigned S_BITS   = 2 * FEATURE_BITS + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [FEATURE_BITS-1:0] m_lat;
  logic [FEATURE_BITS-1:0] g_lat;
  logic [FEATURE_BITS-1:0] r_lat;
  logic [ADDR_BITS-1:0]    base_lat;
  logic                    cont_lat;
  logic [FEATURE_BITS-1:0] m_it;
  logic [FEATURE_BITS-1:0] g_it;
  logic [ACC_BITS-1:0]     acc;

  logic [S_BITS-1:0]       s_c;
  logic [FEATURE_BITS-1:0] half_c;
  logic [S_BITS-1:0]       raw_c;
  logic [S_BITS-1:0]       rem_c;
  logic [ADDR_BITS-1:0]    addr_c;
  logic                    m_end_c;
  logic                    g_end_c;
  logic                    cfg_ok_c;

  // Interleaved address for the tuple held in the counters: even s in the low half, odd s in the high half
  always_comb begin
    s_c     = S_BITS'(acc) + S_BITS'(m_it);
    half_c  = ((m_lat - FEATURE_BITS'(1)) >> 1) + FEATURE_BITS'(1);
    raw_c   = (s_c >> 1) + (s_c[0] ? S_BITS'(half_c) : S_BITS'(0));
    rem_c   = raw_c % S_BITS'(m_lat);
    addr_c  = base_lat + ADDR_BITS'(rem_c);
    m_end_c = (m_it == m_lat - FEATURE_BITS'(1));
    g_end_c = (g_it == g_lat - FEATURE_BITS'(1));
  end

  always_comb begin
    cfg_ok_c = 1'b1;
`ifdef AG_O_CFG_CHECK_EN
    cfg_ok_c = (m_cfg != '0) && (gamma_cfg != '0) && (r_cfg != '0);
`endif
  end

  // Control FSM with registered outputs; abort takes priority over stall
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      m_lat    <= '0;
      g_lat    <= '0;
      r_lat    <= '0;
      base_lat <= '0;
      cont_lat <= 1'b0;
      m_it     <= '0;
      g_it     <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      addr_vld <= 1'b0;
      address  <= '0;
      m_idx    <= '0;
      g_idx    <= '0;
      last     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= addr_vld && last && !((state == RUN) && abort);
      case (state)
        IDLE: begin
          addr_vld <= 1'b0;
          last     <= 1'b0;
          if (start && cfg_ok_c) begin
            state    <= RUN;
            busy     <= 1'b1;
            m_lat    <= m_cfg;
            g_lat    <= gamma_cfg;
            r_lat    <= r_cfg;
            base_lat <= base_cfg;
            cont_lat <= mode_cont;
            m_it     <= '0;
            g_it     <= '0;
            acc      <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            addr_vld <= 1'b0;
            last     <= 1'b0;
          end else if (stall) begin
            addr_vld <= 1'b0;
            last     <= 1'b0;
          end else begin
            addr_vld <= 1'b1;
            address  <= addr_c;
            m_idx    <= m_it;
            g_idx    <= g_it;
            last     <= m_end_c && g_end_c;
            if (m_end_c) begin
              m_it <= '0;
              if (g_end_c) begin
                g_it <= '0;
                acc  <= '0;
                if (!cont_lat) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                g_it <= g_it + FEATURE_BITS'(1);
                acc  <= acc + ACC_BITS'(r_lat);
              end
            end else begin
              m_it <= m_it + FEATURE_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AG_O_CFG_CHECK_EN
  // Sticky refusal flag, cleared by the next accepted start
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_err <= 1'b0;
    end else if ((state == IDLE) && start) begin
      cfg_err <= !cfg_ok_c;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_ag_o_cfg.sv
// Scoreboard bench for ag_o_cfg: driver pushes hand-computed addresses, monitor pops on addr_vld.
module tb_ag_o_cfg;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] m_cfg = '0;
  logic [3:0] gamma_cfg = '0;
  logic [3:0] r_cfg = '0;
  logic [3:0] base_cfg = '0;
  logic       mode_cont = 1'b0;
  logic       stall = 1'b0;
  logic       abort = 1'b0;
  logic       busy, addr_vld, last, done, cfg_err;
  logic [3:0] address, m_idx, g_idx;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] m;
    logic [3:0] g;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;
  logic exp_done_next = 1'b0;

  // Hand-computed M=9,G=3,R=1 sequence and the M=4,G=2,R=2 pass
  int seq9[27] = '{0,5,1,6,2,7,3,8,4, 5,1,6,2,7,3,8,4,0, 1,6,2,7,3,8,4,0,5};
  int seq4[8]  = '{0,2,1,3,1,3,2,0};

  ag_o_cfg #(.FEATURE_BITS(4), .ADDR_BITS(4)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .m_cfg(m_cfg),
    .gamma_cfg(gamma_cfg), .r_cfg(r_cfg), .base_cfg(base_cfg), .mode_cont(mode_cont),
    .stall(stall), .abort(abort), .busy(busy), .addr_vld(addr_vld), .address(address),
    .m_idx(m_idx), .g_idx(g_idx), .last(last), .done(done), .cfg_err(cfg_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int a, input int m, input int g, input bit l);
    exp_t e;
    e.a = 4'(a); e.m = 4'(m); e.g = 4'(g); e.l = l;
    q.push_back(e);
  endtask

  // Monitor: compares every presented address and the done pulse that follows a last
  always @(negedge sys_clk) begin
    exp_t e;
    if (!reset_n) begin
      exp_done_next = 1'b0;
    end else begin
      if (done) done_seen++;
      if (done || exp_done_next) begin
        tests++;
        if (done !== exp_done_next) begin
          fails++;
          $display("FAIL done_pulse: got %0b expected %0b", done, exp_done_next);
        end
      end
      exp_done_next = 1'b0;
      if (addr_vld) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_addr: got address %0d with empty scoreboard", address);
        end else begin
          e = q.pop_front();
          if (address !== e.a || m_idx !== e.m || g_idx !== e.g || last !== e.l) begin
            fails++;
            $display("FAIL addr_tuple: got a=%0d m=%0d g=%0d last=%0b expected a=%0d m=%0d g=%0d last=%0b",
                     address, m_idx, g_idx, last, e.a, e.m, e.g, e.l);
          end
          exp_done_next = e.l;
        end
      end
    end
  end

  task automatic do_start(input int m, input int g, input int r, input int b, input bit c);
    @(posedge sys_clk); #1;
    m_cfg = 4'(m); gamma_cfg = 4'(g); r_cfg = 4'(r); base_cfg = 4'(b); mode_cont = c;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    m_cfg = 4'hF; gamma_cfg = 4'hF; r_cfg = 4'hF; base_cfg = 4'hA; mode_cont = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((busy || q.size() != 0) && n < budget) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check({name, "_timeout"}, int'(busy || q.size() != 0), 0);
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int d0;
    bit prev_stall;
    // Reset values
    #12;
    check("reset_outputs", int'({busy, addr_vld, address, m_idx, g_idx, last, done, cfg_err}), 0);
    @(posedge sys_clk); #1;
    reset_n = 1'b1;

    // M=9,G=3,R=1 base 0, no stall
    for (int i = 0; i < 27; i++) push(seq9[i], i % 9, i / 9, i == 26);
    d0 = done_seen;
    do_start(9, 3, 1, 0, 1'b0);
    check("busy_after_start", int'(busy), 1);
    wait_idle("basic", 100);
    check("basic_done_count", done_seen - d0, 1);
    check("basic_idle", int'(busy), 0);

    // base=3 with stall every 3rd cycle
    for (int i = 0; i < 27; i++) push((seq9[i] + 3) % 16, i % 9, i / 9, i == 26);
    d0 = done_seen;
    do_start(9, 3, 1, 3, 1'b0);
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 200 && (busy || q.size() != 0); cyc++) begin
      stall = (cyc % 3 == 2);
      prev_stall = stall && busy;
      @(posedge sys_clk); #1;
      if (prev_stall) check("stall_gap", int'(addr_vld), 0);
    end
    stall = 1'b0;
    check("stall_drained", q.size(), 0);
    repeat (2) @(posedge sys_clk);
    #1;
    check("stall_done_count", done_seen - d0, 1);

    // Continuous mode M=4,G=2,R=2: three full passes plus two, then abort
    for (int i = 0; i < 26; i++) push(seq4[i % 8], i % 4, (i % 8) / 4, (i % 8) == 7);
    d0 = done_seen;
    do_start(4, 2, 2, 0, 1'b1);
    repeat (26) @(posedge sys_clk);
    #1;
    check("cont_busy", int'(busy), 1);
    abort = 1'b1;
    @(posedge sys_clk); #1;
    abort = 1'b0;
    check("cont_abort_vld", int'(addr_vld), 0);
    check("cont_abort_busy", int'(busy), 0);
    repeat (3) @(posedge sys_clk);
    #1;
    check("cont_drained", q.size(), 0);
    check("cont_done_count", done_seen - d0, 3);

    // Abort after 4 addresses, then G=1 restart from address 0
    for (int i = 0; i < 4; i++) push(seq9[i], i, 0, 1'b0);
    d0 = done_seen;
    do_start(9, 3, 1, 0, 1'b0);
    repeat (4) @(posedge sys_clk);
    #1;
    abort = 1'b1;
    stall = 1'b1;
    @(posedge sys_clk); #1;
    abort = 1'b0;
    stall = 1'b0;
    check("abort_vld", int'(addr_vld), 0);
    check("abort_busy", int'(busy), 0);
    repeat (3) @(posedge sys_clk);
    #1;
    check("abort_no_done", done_seen - d0, 0);
    check("abort_drained", q.size(), 0);
    for (int i = 0; i < 9; i++) push(seq9[i], i, 0, i == 8);
    d0 = done_seen;
    do_start(9, 1, 1, 0, 1'b0);
    wait_idle("g1", 50);
    check("g1_done_count", done_seen - d0, 1);

    // M=1: address is always base, g advances every cycle
    for (int i = 0; i < 3; i++) push(7, 0, i, i == 2);
    d0 = done_seen;
    do_start(1, 3, 5, 7, 1'b0);
    wait_idle("m1", 50);
    check("m1_done_count", done_seen - d0, 1);

    // Start while busy is ignored; reset mid-run clears everything at once
    push(0, 0, 0, 1'b0); push(2, 1, 0, 1'b0); push(1, 2, 0, 1'b0);
    push(3, 3, 0, 1'b0); push(1, 0, 1, 1'b0);
    do_start(4, 2, 2, 0, 1'b0);
    @(posedge sys_clk); #1;
    start = 1'b1; m_cfg = 4'd9; gamma_cfg = 4'd1; r_cfg = 4'd1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk); #2;
    reset_n = 1'b0;
    #1;
    check("reset_midrun_outputs", int'({busy, addr_vld, address, m_idx, g_idx, last, done, cfg_err}), 0);
    check("reset_midrun_drained", q.size(), 0);
    @(posedge sys_clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_stays_idle", int'({busy, addr_vld}), 0);

`ifdef AG_O_CFG_CHECK_EN
    // Refused start with m_cfg=0, then a legal start clears the flag
    do_start(0, 3, 1, 0, 1'b0);
    check("cfg_err_set", int'(cfg_err), 1);
    check("cfg_err_idle", int'(busy), 0);
    repeat (2) @(posedge sys_clk);
    #1;
    check("cfg_err_sticky", int'(cfg_err), 1);
    push(2, 0, 0, 1'b1);
    do_start(1, 1, 1, 2, 1'b0);
    check("cfg_err_cleared", int'(cfg_err), 0);
    wait_idle("cfg_legal", 20);
`else
    check("cfg_err_tied", int'(cfg_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
